// File: rtl/mcpu_core_pkg.sv
// Shared decode-stage definitions: packet geometry, instruction field positions, FIFO entry type.
package mcpu_core_pkg;

  localparam int unsigned NSLOTS       = 4;
  localparam int unsigned INST_W       = 32;
  localparam int unsigned VPC_W        = 28;
  localparam int unsigned PKT_W        = NSLOTS * INST_W;

  // Instruction field positions
  localparam int unsigned RS_LSB       = 0;
  localparam int unsigned RT_LSB       = 5;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned PRED_INV_BIT = 31;
  localparam int unsigned PRED_REG_LSB = 29;
  localparam int unsigned PRED_REG_W   = 2;
  localparam int unsigned PRED_W       = PRED_REG_W + 1;

  typedef struct packed {
    logic [VPC_W-1:0] virtpc;
    logic             inst_pf;
    logic [PKT_W-1:0] packet;
  } decode_entry_t;

endpackage

// File: rtl/mcpu_core_skid_fifo2.sv
// Two-entry FIFO of decode entries with synchronous flush; head is read straight from storage.
module mcpu_core_skid_fifo2
  import mcpu_core_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  decode_entry_t wdata_i,
  output decode_entry_t rdata_o,
  output logic [1:0]    count_o
);

  decode_entry_t mem_q [2];
  decode_entry_t mem_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          push_ok, pop_ok;

  // Guard against overflow/underflow so pointers and count can never desynchronise
  assign push_ok = push_i & (count_q != 2'd2);
  assign pop_ok  = pop_i & (count_q != 2'd0);

  // Next-state: flush wins over push/pop and drops the in-cycle push
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + 2'd1;
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  // State registers; storage is cleared on reset so data outputs read zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mcpu_core_stage_decode.sv
// Decode stage: skid-buffers fetched packets and presents the head with pre-extracted fields.
module mcpu_core_stage_decode
  import mcpu_core_pkg::*;
(
  input  logic                      clkrst_core_clk,
  input  logic                      clkrst_core_rst_n,
  input  logic [VPC_W-1:0]          f2d_out_virtpc,
  input  logic                      f2d_in_inst_pf,
  input  logic [PKT_W-1:0]          ic2d_packet,
  input  logic                      d_valid_in,
  output logic                      d_ready_out,
  output logic                      d_valid_out,
  input  logic                      d_out_ok,
  input  logic                      pipe_flush,
  output logic [VPC_W-1:0]          d2e_virtpc,
  output logic                      d2e_inst_pf,
  output logic [PKT_W-1:0]          d2e_packet,
  output logic [NSLOTS*REG_W-1:0]   d2rf_rs_addr,
  output logic [NSLOTS*REG_W-1:0]   d2rf_rt_addr,
  output logic [NSLOTS*PRED_W-1:0]  d2e_pred
);

  decode_entry_t wr_entry;
  decode_entry_t head;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign wr_entry.virtpc  = f2d_out_virtpc;
  assign wr_entry.inst_pf = f2d_in_inst_pf;
  assign wr_entry.packet  = ic2d_packet;

  // A valid arriving while not ready is the in-flight read; it still fits unless already full
  assign push = d_valid_in & (count != 2'd2);

  assign d_valid_out = (count != 2'd0) & ~pipe_flush;
  assign pop         = d_valid_out & d_out_ok;
  // Only one read may be outstanding beyond the head, so stop at count 1 unless it drains
  assign d_ready_out = (count == 2'd0) | ((count == 2'd1) & pop);

  mcpu_core_skid_fifo2 u_fifo (
    .clk_i   (clkrst_core_clk),
    .rst_ni  (clkrst_core_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (pipe_flush),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (count)
  );

  assign d2e_virtpc  = head.virtpc;
  assign d2e_inst_pf = head.inst_pf;
  assign d2e_packet  = head.packet;

  for (genvar s = 0; s < NSLOTS; s++) begin : g_slot
    logic [INST_W-1:0] inst;
    assign inst = head.packet[s*INST_W +: INST_W];
    assign d2rf_rs_addr[s*REG_W +: REG_W] = inst[RS_LSB +: REG_W];
    assign d2rf_rt_addr[s*REG_W +: REG_W] = inst[RT_LSB +: REG_W];
    assign d2e_pred[s*PRED_W +: PRED_W]   = {inst[PRED_INV_BIT], inst[PRED_REG_LSB +: PRED_REG_W]};
  end

  // Fetch must never present a packet when both entries are occupied (flush cycle excepted)
  overflow_a: assert property (@(posedge clkrst_core_clk) disable iff (!clkrst_core_rst_n)
                               !(d_valid_in && (count == 2'd2) && !pipe_flush));

endmodule

// File: tb/tb_mcpu_core_stage_decode.sv
// Self-checking bench for the decode stage: directed scenarios plus randomized traffic vs a queue model.
module tb_mcpu_core_stage_decode;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [27:0]  vpc;
  logic         pf;
  logic [127:0] pkt;
  logic         vin, ok, flush;

  wire          d_ready_out, d_valid_out;
  wire  [27:0]  d2e_virtpc;
  wire          d2e_inst_pf;
  wire  [127:0] d2e_packet;
  wire  [19:0]  d2rf_rs_addr, d2rf_rt_addr;
  wire  [11:0]  d2e_pred;

  always #5 clk = ~clk;

  mcpu_core_stage_decode dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .f2d_out_virtpc    (vpc),
    .f2d_in_inst_pf    (pf),
    .ic2d_packet       (pkt),
    .d_valid_in        (vin),
    .d_ready_out       (d_ready_out),
    .d_valid_out       (d_valid_out),
    .d_out_ok          (ok),
    .pipe_flush        (flush),
    .d2e_virtpc        (d2e_virtpc),
    .d2e_inst_pf       (d2e_inst_pf),
    .d2e_packet        (d2e_packet),
    .d2rf_rs_addr      (d2rf_rs_addr),
    .d2rf_rt_addr      (d2rf_rt_addr),
    .d2e_pred          (d2e_pred)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [27:0]  pc;
    logic         pf;
    logic [127:0] pkt;
  } ent_t;

  ent_t         mq[$];
  logic         e_valid, e_ready, e_has;
  logic [208:0] e_data;
  wire  [208:0] o_data = {d2e_virtpc, d2e_inst_pf, d2e_packet, d2rf_rs_addr, d2rf_rt_addr, d2e_pred};

  // All visible head fields of an entry, derived from the instruction format
  function automatic logic [208:0] expand(input ent_t e);
    logic [19:0] rs, rt;
    logic [11:0] pr;
    logic [31:0] inst;
    for (int s = 0; s < 4; s++) begin
      inst = e.pkt[32*s +: 32];
      rs[5*s +: 5] = inst % 32;
      rt[5*s +: 5] = (inst / 32) % 32;
      pr[3*s +: 3] = inst / 32'h2000_0000;
    end
    return {e.pc, e.pf, e.pkt, rs, rt, pr};
  endfunction

  task automatic expect_now();
    e_has   = mq.size() != 0;
    e_valid = e_has && !flush;
    e_ready = (mq.size() == 0) || (mq.size() == 1 && e_valid && ok);
    if (e_has) e_data = expand(mq[0]);
  endtask

  // Advance one clock and update the model with the inputs held this cycle
  task automatic tick();
    bit   pop, push;
    ent_t n;
    expect_now();
    pop  = e_valid && ok;
    push = vin && !flush && (mq.size() < 2);
    n    = '{pc: vpc, pf: pf, pkt: pkt};
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(n);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [27:0] p, input logic f, input logic [127:0] k,
                       input logic o, input logic fl);
    vin = v; vpc = p; pf = f; pkt = k; ok = o; flush = fl;
  endtask

  function automatic logic [127:0] rnd_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 28'h0, 0, 128'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({d_valid_out, d_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1", d_valid_out, d_ready_out);
    end
    n_cmp++;
    if (o_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", o_data);
    end
    rst_n = 1'b1;
    mq.delete();
    @(negedge clk);
  endtask

  task automatic test_single();
    drive(1, 28'h10, 0, 128'h0000_00A3, 1, 0);
    #1;
    n_cmp++;
    if ({d_valid_out, d_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL single_pre: got v=%b r=%b want v=0 r=1", d_valid_out, d_ready_out);
    end
    tick();
    drive(0, 28'h0, 0, 128'h0, 1, 0);
    #1;
    n_cmp++;
    if ({d_valid_out, d2e_virtpc, d2rf_rs_addr[4:0], d2rf_rt_addr[4:0], d2e_pred[2:0]}
        !== {1'b1, 28'h10, 5'd3, 5'd5, 3'd0}) begin
      n_bad++;
      $display("FAIL single_out: got v=%b pc=%h rs=%0d rt=%0d pred=%b want v=1 pc=10 rs=3 rt=5 pred=000",
               d_valid_out, d2e_virtpc, d2rf_rs_addr[4:0], d2rf_rt_addr[4:0], d2e_pred[2:0]);
    end
    tick();
    #1;
    n_cmp++;
    if ({d_valid_out, d_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL single_post: got v=%b r=%b want v=0 r=1", d_valid_out, d_ready_out);
    end
  endtask

  task automatic test_backpressure();
    drive(1, 28'h20, 0, rnd_pkt(), 0, 0);
    tick();
    drive(1, 28'h21, 0, rnd_pkt(), 0, 0);
    #1;
    n_cmp++;
    if ({d_valid_out, d_ready_out} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_inflight: got v=%b r=%b want v=1 r=0", d_valid_out, d_ready_out);
    end
    tick();
    drive(0, 28'h0, 0, 128'h0, 0, 0);
    #1;
    n_cmp++;
    if ({d_valid_out, d_ready_out, d2e_virtpc} !== {2'b10, 28'h20}) begin
      n_bad++;
      $display("FAIL bp_full: got v=%b r=%b pc=%h want v=1 r=0 pc=20", d_valid_out, d_ready_out, d2e_virtpc);
    end
    ok = 1'b1;
    #1;
    n_cmp++;
    if ({d_ready_out, d2e_virtpc} !== {1'b0, 28'h20}) begin
      n_bad++;
      $display("FAIL bp_pop_a: got r=%b pc=%h want r=0 pc=20", d_ready_out, d2e_virtpc);
    end
    tick();
    #1;
    n_cmp++;
    if ({d_valid_out, d_ready_out, d2e_virtpc} !== {2'b11, 28'h21}) begin
      n_bad++;
      $display("FAIL bp_pop_b: got v=%b r=%b pc=%h want v=1 r=1 pc=21", d_valid_out, d_ready_out, d2e_virtpc);
    end
    tick();
    #1;
    n_cmp++;
    if ({d_valid_out, d_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_empty: got v=%b r=%b want v=0 r=1", d_valid_out, d_ready_out);
    end
  endtask

  task automatic test_stream();
    logic [27:0] got[$];
    for (int i = 0; i < 9; i++) begin
      drive(i < 8, 28'(i), 0, rnd_pkt(), 1, 0);
      #1;
      expect_now();
      n_cmp++;
      if ({d_valid_out, d_ready_out} !== {e_valid, 1'b1}) begin
        n_bad++;
        $display("FAIL stream_hs[%0d]: got v=%b r=%b want v=%b r=1", i, d_valid_out, d_ready_out, e_valid);
      end
      if (e_has) begin
        n_cmp++;
        if (o_data !== e_data) begin
          n_bad++;
          $display("FAIL stream_data[%0d]: got %h want %h", i, o_data, e_data);
        end
      end
      if (d_valid_out) got.push_back(d2e_virtpc);
      tick();
    end
    n_cmp++;
    if (got.size() != 8) begin
      n_bad++;
      $display("FAIL stream_count: got %0d want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (got[i] !== 28'(i)) begin
          n_bad++;
          $display("FAIL stream_order[%0d]: got %h want %h", i, got[i], i);
        end
      end
    end
  endtask

  task automatic test_flush();
    drive(1, 28'h30, 0, rnd_pkt(), 0, 0);
    tick();
    drive(1, 28'h31, 0, rnd_pkt(), 0, 0);
    tick();
    drive(1, 28'h99, 0, rnd_pkt(), 1, 1);
    #1;
    n_cmp++;
    if (d_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_valid: got v=%b want v=0", d_valid_out);
    end
    tick();
    drive(1, 28'h40, 0, rnd_pkt(), 0, 0);
    #1;
    n_cmp++;
    if ({d_valid_out, d_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_empty: got v=%b r=%b want v=0 r=1", d_valid_out, d_ready_out);
    end
    tick();
    drive(0, 28'h0, 0, 128'h0, 1, 0);
    #1;
    n_cmp++;
    if ({d_valid_out, d2e_virtpc} !== {1'b1, 28'h40}) begin
      n_bad++;
      $display("FAIL flush_first: got v=%b pc=%h want v=1 pc=40", d_valid_out, d2e_virtpc);
    end
    tick();
  endtask

  task automatic test_pagefault();
    logic [127:0] k;
    k = rnd_pkt();
    k[95:64] = 32'hE000_0000;
    drive(1, 28'h55, 1, k, 0, 0);
    tick();
    drive(0, 28'h0, 0, 128'h0, 1, 0);
    #1;
    n_cmp++;
    if ({d_valid_out, d2e_inst_pf, d2e_pred[8:6]} !== {1'b1, 1'b1, 3'b111}) begin
      n_bad++;
      $display("FAIL pf: got v=%b pf=%b pred2=%b want v=1 pf=1 pred2=111",
               d_valid_out, d2e_inst_pf, d2e_pred[8:6]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive((mq.size() < 2) ? 1'($urandom % 2) : 1'b0, 28'($urandom), 1'($urandom % 2), rnd_pkt(),
            1'($urandom % 2), ($urandom % 16) == 0);
      #1;
      expect_now();
      n_cmp++;
      if ({d_valid_out, d_ready_out} !== {e_valid, e_ready}) begin
        n_bad++;
        $display("FAIL rand_hs[%0d]: got v=%b r=%b want v=%b r=%b", i, d_valid_out, d_ready_out,
                 e_valid, e_ready);
      end
      if (e_has) begin
        n_cmp++;
        if (o_data !== e_data) begin
          n_bad++;
          $display("FAIL rand_data[%0d]: got %h want %h", i, o_data, e_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1, 28'h60, 0, rnd_pkt(), 0, 0);
    tick();
    drive(1, 28'h61, 0, rnd_pkt(), 0, 0);
    tick();
    drive(0, 28'h0, 0, 128'h0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d_valid_out, d_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL areset_hs: got v=%b r=%b want v=0 r=1", d_valid_out, d_ready_out);
    end
    n_cmp++;
    if (o_data !== '0) begin
      n_bad++;
      $display("FAIL areset_data: got %h want 0", o_data);
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 28'h0, 0, 128'h0, 1, 0);
      #1;
      n_cmp++;
      if ({d_valid_out, d_ready_out} !== 2'b01) begin
        n_bad++;
        $display("FAIL areset_ghost[%0d]: got v=%b r=%b want v=0 r=1", i, d_valid_out, d_ready_out);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush();
    test_pagefault();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
